// File: rtl/cache_fill_pkg.sv
// Shared cache definitions: fill FSM state encoding, block geometry and
// block-base alignment used by the fill engine and the tag logic.
package cache_fill_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_IDX_W      = 3;

    // Clears the word-offset and byte-in-word bits so a 16-bit word block starts aligned.
    function automatic logic [63:0] block_base(input logic [63:0] addr, input int idx_w);
        return addr & ~((64'd1 << (idx_w + 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating up-counter with synchronous clear; tracks word positions within
// one cache block (issued addresses or received words).
module fill_word_counter
    import cache_fill_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill initiator: on a miss, streams block read addresses to the
// pipelined memory and writes each returned word, validating the tag on the last.
module cache_fill_fsm
    import cache_fill_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = cache_fill_pkg::WORDS_PER_BLOCK,
    parameter int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [15:0]           memory_data,
    input  logic                  memory_data_valid,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic                  fsm_busy,
    output logic                  write_data_array,
    output logic [WORD_IDX_W-1:0] word_index,
    output logic [15:0]           fill_data,
    output logic                  write_tag_array
);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

    fill_state_e           state_q;
    fill_state_e           state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] base_d;

    logic                  issue_clr;
    logic                  issue_inc;
    logic                  recv_clr;
    logic                  recv_inc;
    logic [WORD_IDX_W-1:0] issue_cnt;
    logic [WORD_IDX_W-1:0] recv_cnt;

    // Issue count saturates on the last word, so the final address is simply re-read.
    fill_word_counter #(.W(WORD_IDX_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (issue_clr),
        .inc   (issue_inc),
        .count (issue_cnt)
    );

    fill_word_counter #(.W(WORD_IDX_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (recv_clr),
        .inc   (recv_inc),
        .count (recv_cnt)
    );

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_clr        = 1'b0;
        issue_inc        = 1'b0;
        recv_clr         = 1'b0;
        recv_inc         = 1'b0;
        memory_address   = '0;
        mem_enable       = 1'b0;
        mem_wr           = 1'b0;
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        word_index       = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_d    = ADDR_WIDTH'(block_base(64'(miss_address), WORD_IDX_W));
                    issue_clr = 1'b1;
                    recv_clr  = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                mem_enable     = 1'b1;
                fsm_busy       = 1'b1;
                memory_address = base_q + ADDR_WIDTH'({issue_cnt, 1'b0});
                issue_inc      = 1'b1;
                // Words return in issue order, so the receive count is the word offset.
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_index       = recv_cnt;
                    fill_data        = memory_data;
                    recv_inc         = 1'b1;
                    if (recv_cnt == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: fixed vector table for the nominal fill, then a
// queue-based pipelined memory plus block-level reference model for the rest.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic [15:0] memory_address;
    logic        mem_enable;
    logic        mem_wr;
    logic        fsm_busy;
    logic        write_data_array;
    logic [2:0]  word_index;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .memory_address    (memory_address),
        .mem_enable        (mem_enable),
        .mem_wr            (mem_wr),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .word_index        (word_index),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Block-level reference: busy flag, block base, cycles in fill, words received.
    bit          m_busy = 0;
    logic [15:0] m_base = '0;
    int          m_k    = 0;
    int          m_recv = 0;

    typedef struct {
        logic [15:0] a;
        int          rdy;
    } req_t;
    req_t q[$];
    int lat       = 4;
    int stall     = 0;
    int gap_after = -1;
    int gap_len   = 0;
    int stall_pct = 0;
    int ret_cnt   = 0;
    bit force_v   = 0;
    bit mem_auto  = 0;

    int busy_cnt, wr_cnt, tag_cnt;

    typedef struct {
        bit          miss;
        logic [15:0] maddr;
        bit          v;
        logic [15:0] d;
        bit          e_busy;
        logic [15:0] e_addr;
        bit          e_wr;
        logic [2:0]  e_idx;
        logic [15:0] e_data;
        bit          e_tag;
    } vec_t;
    vec_t tbl[17];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + ((a - 16'h1230) >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, fsm_busy, 0);
        chk({tag, "_en"}, mem_enable, 0);
        chk({tag, "_wr"}, mem_wr, 0);
        chk({tag, "_addr"}, memory_address, 0);
        chk({tag, "_wda"}, write_data_array, 0);
        chk({tag, "_idx"}, word_index, 0);
        chk({tag, "_data"}, fill_data, 0);
        chk({tag, "_tag"}, write_tag_array, 0);
    endtask

    task automatic check_model();
        bit          wr;
        logic [15:0] ea;
        wr = m_busy && memory_data_valid;
        ea = m_busy ? m_base + 16'(2 * (m_k > 7 ? 7 : m_k)) : 16'h0;
        chk("busy", fsm_busy, m_busy);
        chk("mem_enable", mem_enable, m_busy);
        chk("mem_wr", mem_wr, 0);
        chk("mem_addr", memory_address, ea);
        chk("write_data", write_data_array, wr);
        chk("word_index", word_index, wr ? 32'(m_recv) : 32'd0);
        chk("fill_data", fill_data, wr ? memory_data : 16'h0);
        chk("tag", write_tag_array, wr && (m_recv == 7));
        if (wr) chk("word_order", memory_data, mem_word(m_base + 16'(2 * m_recv)));
    endtask

    task automatic model_update();
        if (m_busy) begin
            if (memory_data_valid) begin
                if (m_recv == 7) m_busy = 0;
                m_recv++;
            end
            m_k++;
        end else if (miss_detected) begin
            m_busy = 1;
            m_base = miss_address & 16'hFFF0;
            m_k    = 0;
            m_recv = 0;
        end
    endtask

    task automatic mem_drive();
        req_t r;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        if (!mem_auto) return;
        if (!mem_enable) begin
            q.delete();
            stall   = 0;
            ret_cnt = 0;
            if (force_v) begin
                memory_data_valid = 1'b1;
                memory_data       = 16'($urandom);
            end
            return;
        end
        if (stall > 0) begin
            stall--;
        end else if (q.size() > 0 && q[0].rdy <= cyc) begin
            r = q.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = mem_word(r.a);
            ret_cnt++;
            if (ret_cnt == gap_after) stall = gap_len;
            else if (int'($urandom_range(99)) < stall_pct) stall = int'($urandom_range(3, 1));
        end
    endtask

    task automatic tick();
        #1;
        check_model();
        busy_cnt += int'(fsm_busy);
        wr_cnt   += int'(write_data_array);
        tag_cnt  += int'(write_tag_array);
        if (mem_enable) q.push_back('{memory_address, cyc + lat});
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((m_busy || fsm_busy) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL fill_timeout cyc=%0d got=%0d cycles expected=<%0d", cyc, n, max);
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        wr_cnt   = 0;
        tag_cnt  = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        miss_detected = 1'b0;
        miss_address = 16'h0;
        memory_data = 16'h0;
        memory_data_valid = 1'b0;
        clear_counts();

        // Nominal 4-cycle-latency fill of block 0x1230, then stray valids while idle.
        for (int t = 0; t < 17; t++) begin
            tbl[t] = '{default: '0};
            if (t == 0) begin
                tbl[t].miss  = 1'b1;
                tbl[t].maddr = 16'h1234;
            end
            if (t >= 1 && t <= 12) begin
                tbl[t].e_busy = 1'b1;
                tbl[t].e_addr = 16'h1230 + 16'(2 * ((t - 1) > 7 ? 7 : (t - 1)));
            end
            if (t >= 5 && t <= 12) begin
                tbl[t].v      = 1'b1;
                tbl[t].d      = 16'hA000 + 16'(t - 5);
                tbl[t].e_wr   = 1'b1;
                tbl[t].e_idx  = 3'(t - 5);
                tbl[t].e_data = tbl[t].d;
            end
            if (t == 12) tbl[t].e_tag = 1'b1;
            if (t >= 13) begin
                tbl[t].v = 1'b1;
                tbl[t].d = 16'hDEAD;
            end
        end

        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        memory_data_valid = 1'b1;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int t = 0; t < 17; t++) begin
            miss_detected     = tbl[t].miss;
            miss_address      = tbl[t].maddr;
            memory_data_valid = tbl[t].v;
            memory_data       = tbl[t].d;
            #1;
            chk($sformatf("nom_busy_T%0d", t), fsm_busy, tbl[t].e_busy);
            chk($sformatf("nom_en_T%0d", t), mem_enable, tbl[t].e_busy);
            chk($sformatf("nom_addr_T%0d", t), memory_address, tbl[t].e_addr);
            chk($sformatf("nom_wda_T%0d", t), write_data_array, tbl[t].e_wr);
            chk($sformatf("nom_idx_T%0d", t), word_index, tbl[t].e_idx);
            chk($sformatf("nom_data_T%0d", t), fill_data, tbl[t].e_data);
            chk($sformatf("nom_tag_T%0d", t), write_tag_array, tbl[t].e_tag);
            chk($sformatf("nom_memwr_T%0d", t), mem_wr, 0);
            @(posedge clk);
            #1;
            cyc++;
        end

        mem_auto = 1'b1;
        miss_detected = 1'b0;
        mem_drive();

        // Miss and address changes during a fill are ignored; back-to-back miss at T13.
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        for (int i = 0; i < 3; i++) tick();
        miss_address = 16'h5678;
        for (int i = 0; i < 10; i++) tick();
        chk("b2b_idle_T13", fsm_busy, 0);
        tick();
        miss_detected = 1'b0;
        #1;
        chk("b2b_busy_T14", fsm_busy, 1);
        chk("b2b_addr_T14", memory_address, 16'h5670);
        run_until_idle(100);

        // Slow memory: two-cycle valid gap after the fourth word.
        gap_after = 4;
        gap_len   = 2;
        clear_counts();
        miss_detected = 1'b1;
        miss_address  = 16'h2468;
        tick();
        miss_detected = 1'b0;
        run_until_idle(100);
        chk("slow_busy_cycles", busy_cnt, 14);
        chk("slow_writes", wr_cnt, 8);
        chk("slow_tags", tag_cnt, 1);
        gap_after = -1;

        // Reset asserted at T7 of a fill.
        clear_counts();
        miss_detected = 1'b1;
        miss_address  = 16'h4444;
        tick();
        miss_detected = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_busy", fsm_busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst_no_tag", tag_cnt, 0);
        q.delete();
        m_busy = 0;
        memory_data_valid = 1'b0;
        memory_data = 16'h0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        mem_drive();
        clear_counts();
        miss_detected = 1'b1;
        miss_address  = 16'h0000;
        tick();
        miss_detected = 1'b0;
        run_until_idle(100);
        chk("postrst_writes", wr_cnt, 8);
        chk("postrst_tags", tag_cnt, 1);

        // Top-of-memory block.
        clear_counts();
        miss_detected = 1'b1;
        miss_address  = 16'hFFFF;
        tick();
        miss_detected = 1'b0;
        #1;
        chk("top_first_addr", memory_address, 16'hFFF0);
        run_until_idle(100);
        chk("top_writes", wr_cnt, 8);
        chk("top_tags", tag_cnt, 1);

        // Randomized misses, latencies, valid gaps and stray idle valids.
        clear_counts();
        for (int i = 0; i < 2000; i++) begin
            if (!m_busy) begin
                lat       = int'($urandom_range(6, 1));
                stall_pct = int'($urandom_range(30, 0));
            end
            force_v       = 1'($urandom);
            miss_detected = ($urandom_range(99) < 25);
            miss_address  = 16'($urandom);
            tick();
        end
        miss_detected = 1'b0;
        force_v = 1'b0;
        run_until_idle(200);
        checks++;
        if (tag_cnt < 10) begin
            errors++;
            $display("FAIL random_fills cyc=%0d got=%0d tags expected>=10", cyc, tag_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
